// File: rtl/resize_coord_gen.sv
// ---------------------------------------------------------------------------
// resize_coord_gen
//
// Computes fixed-point horizontal and vertical scale factors with one shared
// restoring divider. It then streams one source-coordinate record per
// destination pixel, in raster order, over a valid/ready interface.
//
// Each record carries the integer taps x0/x1 and y0/y1 and the fractional
// weights fx/fy. These feed the nearest-neighbour or bilinear pixel datapath.
//
// Optional build macro: RESIZE_CENTER_ALIGN_EN
//   defined   : half-pixel centre alignment of the accumulators
//   undefined : corner alignment (accumulators start at 0)
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       job request, accepted only when idle
//   src_w, src_h, dst_w, dst_h  image dimensions, latched on accepted start
//   busy                        job in progress
//   done                        one-cycle end-of-job pulse
//   cfg_err                     a dimension was zero; held until next start
//   out_valid, out_ready        record handshake
//   out_x0/x1, out_y0/y1        source tap coordinates
//   out_fx, out_fy              fractional weights
//   out_eol, out_eof            last record of row / of frame
// ---------------------------------------------------------------------------
module resize_coord_gen #(
   parameter int DIM_W  = 12,
   parameter int FRAC_W = 11,
   parameter int SF_W   = DIM_W + FRAC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIM_W-1:0]  src_w,
   input  logic [DIM_W-1:0]  src_h,
   input  logic [DIM_W-1:0]  dst_w,
   input  logic [DIM_W-1:0]  dst_h,
   output logic              busy,
   output logic              done,
   output logic              cfg_err,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DIM_W-1:0]  out_x0,
   output logic [DIM_W-1:0]  out_x1,
   output logic [DIM_W-1:0]  out_y0,
   output logic [DIM_W-1:0]  out_y1,
   output logic [FRAC_W-1:0] out_fx,
   output logic [FRAC_W-1:0] out_fy,
   output logic              out_eol,
   output logic              out_eof
);

   localparam int ACC_W = SF_W + 2;
   localparam int IP_W  = ACC_W - FRAC_W;
   localparam int CNT_W = $clog2(2 * SF_W + 1);
   // Divider step counter: 0 = load/screen, 1..SF_W = x, SF_W+1..2*SF_W = y
   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(SF_W);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(2 * SF_W);

   localparam logic [2:0] S_RESET           = 3'd0;
   localparam logic [2:0] S_READY           = 3'd1;
   localparam logic [2:0] S_CALC_SF         = 3'd2;
   localparam logic [2:0] S_START_PIXEL_GEN = 3'd3;
   localparam logic [2:0] S_INDEX           = 3'd4;
   localparam logic [2:0] S_DONE            = 3'd5;

   // Per-axis storage: index 0 = horizontal, 1 = vertical
   logic [2:0]        state_reg;
   logic [DIM_W-1:0]  src_reg  [2];
   logic [DIM_W-1:0]  dst_reg  [2];
   logic [SF_W-1:0]   sf_reg   [2];
   logic [ACC_W-1:0]  acc_reg  [2];
   logic [ACC_W-1:0]  acc_next [2];
   logic [ACC_W-1:0]  acc_init [2];
   logic [DIM_W-1:0]  pos_reg  [2];
   logic [DIM_W-1:0]  pos_next [2];
   logic [DIM_W-1:0]  tap0     [2];
   logic [DIM_W-1:0]  tap1     [2];
   logic [FRAC_W-1:0] frac     [2];

   logic [CNT_W-1:0]  calc_cnt_reg;
   logic [SF_W-1:0]   dq_reg;       // dividend shifts out, quotient shifts in
   logic [DIM_W-1:0]  rem_reg;
   logic [DIM_W-1:0]  divisor;
   logic [DIM_W:0]    trial;
   logic              q_bit;
   logic [DIM_W-1:0]  rem_step;
   logic [SF_W-1:0]   dq_step;

   logic              zero_dim;
   logic              row_end;
   logic              frame_end;
   logic              advance;
   logic              eol_next;

   assign busy      = (state_reg != S_READY) && (state_reg != S_RESET);
   assign done      = (state_reg == S_DONE);
   assign out_valid = (state_reg == S_INDEX);

   // Restoring division step
   assign divisor  = (calc_cnt_reg <= X_LAST) ? dst_reg[0] : dst_reg[1];
   assign trial    = {rem_reg, dq_reg[SF_W-1]};
   assign q_bit    = (trial >= {1'b0, divisor});
   assign rem_step = q_bit ? DIM_W'(trial - {1'b0, divisor}) : trial[DIM_W-1:0];
   assign dq_step  = {dq_reg[SF_W-2:0], q_bit};

   assign zero_dim  = (src_reg[0] == '0) || (src_reg[1] == '0) ||
                      (dst_reg[0] == '0) || (dst_reg[1] == '0);
   assign row_end   = (pos_reg[0] == dst_reg[0] - 1'b1);
   assign frame_end = row_end && (pos_reg[1] == dst_reg[1] - 1'b1);

   // Output registers load the record for the next position. They load once
   // on entry to pixel generation and again on each accepted non-final record.
   assign advance = (state_reg == S_START_PIXEL_GEN) ||
                    ((state_reg == S_INDEX) && out_ready && !frame_end);

   always_comb begin
      pos_next[0] = pos_reg[0] + 1'b1;
      acc_next[0] = acc_reg[0] + ACC_W'(sf_reg[0]);
      pos_next[1] = pos_reg[1];
      acc_next[1] = acc_reg[1];
      if (state_reg == S_START_PIXEL_GEN) begin
         pos_next[0] = '0;
         acc_next[0] = acc_init[0];
         pos_next[1] = '0;
         acc_next[1] = acc_init[1];
      end else if (row_end) begin
         pos_next[0] = '0;
         acc_next[0] = acc_init[0];
         pos_next[1] = pos_reg[1] + 1'b1;
         acc_next[1] = acc_reg[1] + ACC_W'(sf_reg[1]);
      end
   end

   assign eol_next = (pos_next[0] == dst_reg[0] - 1'b1);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         logic [IP_W-1:0]   ipart;
         logic [DIM_W-1:0]  last;
         logic [DIM_W-1:0]  t0;
         logic [FRAC_W-1:0] f;

         assign ipart = acc_next[gi][ACC_W-1:FRAC_W];
         assign last  = src_reg[gi] - 1'b1;

         // Negative positions clamp to the first tap. Positions at or past the
         // last source pixel clamp to it. Both clamps use a zero weight.
         always_comb begin
            t0 = '0;
            f  = '0;
            if (!acc_next[gi][ACC_W-1]) begin
               if (ipart >= IP_W'(last)) begin
                  t0 = last;
               end else begin
                  t0 = ipart[DIM_W-1:0];
                  f  = acc_next[gi][FRAC_W-1:0];
               end
            end
         end

         assign tap0[gi] = t0;
         assign tap1[gi] = (t0 == last) ? last : t0 + 1'b1;
         assign frac[gi] = f;

`ifdef RESIZE_CENTER_ALIGN_EN
         localparam logic [ACC_W-1:0] HALF_PIX = ACC_W'(1) << (FRAC_W - 1);
         assign acc_init[gi] = ACC_W'(sf_reg[gi] >> 1) - HALF_PIX;
`else
         assign acc_init[gi] = '0;
`endif
      end
   endgenerate

   // Control FSM and divider
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= S_RESET;
         cfg_err      <= 1'b0;
         calc_cnt_reg <= '0;
         dq_reg       <= '0;
         rem_reg      <= '0;
         for (int i = 0; i < 2; i++) begin
            src_reg[i] <= '0;
            dst_reg[i] <= '0;
            sf_reg[i]  <= '0;
         end
      end else begin
         case (state_reg)
            S_RESET: state_reg <= S_READY;
            S_READY: begin
               if (start) begin
                  src_reg[0]   <= src_w;
                  src_reg[1]   <= src_h;
                  dst_reg[0]   <= dst_w;
                  dst_reg[1]   <= dst_h;
                  cfg_err      <= 1'b0;
                  calc_cnt_reg <= '0;
                  state_reg    <= S_CALC_SF;
               end
            end
            S_CALC_SF: begin
               calc_cnt_reg <= calc_cnt_reg + 1'b1;
               if (calc_cnt_reg == '0) begin
                  // The first cycle screens the dimensions and loads the x dividend
                  if (zero_dim) begin
                     cfg_err   <= 1'b1;
                     state_reg <= S_DONE;
                  end else begin
                     dq_reg  <= SF_W'({src_reg[0], {FRAC_W{1'b0}}});
                     rem_reg <= '0;
                  end
               end else begin
                  dq_reg  <= dq_step;
                  rem_reg <= rem_step;
                  if (calc_cnt_reg == X_LAST) begin
                     sf_reg[0] <= dq_step;
                     dq_reg    <= SF_W'({src_reg[1], {FRAC_W{1'b0}}});
                     rem_reg   <= '0;
                  end
                  if (calc_cnt_reg == Y_LAST) begin
                     sf_reg[1] <= dq_step;
                     state_reg <= S_START_PIXEL_GEN;
                  end
               end
            end
            S_START_PIXEL_GEN: state_reg <= S_INDEX;
            S_INDEX: begin
               if (out_ready && frame_end) state_reg <= S_DONE;
            end
            S_DONE:  state_reg <= S_READY;
            default: state_reg <= S_RESET;
         endcase
      end
   end

   // Coordinate datapath and registered record outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            acc_reg[i] <= '0;
            pos_reg[i] <= '0;
         end
         out_x0  <= '0;
         out_x1  <= '0;
         out_y0  <= '0;
         out_y1  <= '0;
         out_fx  <= '0;
         out_fy  <= '0;
         out_eol <= 1'b0;
         out_eof <= 1'b0;
      end else if (advance) begin
         for (int i = 0; i < 2; i++) begin
            acc_reg[i] <= acc_next[i];
            pos_reg[i] <= pos_next[i];
         end
         out_x0  <= tap0[0];
         out_x1  <= tap1[0];
         out_y0  <= tap0[1];
         out_y1  <= tap1[1];
         out_fx  <= frac[0];
         out_fy  <= frac[1];
         out_eol <= eol_next;
         out_eof <= eol_next && (pos_next[1] == dst_reg[1] - 1'b1);
      end
   end

endmodule
